bus_adapter_outer_in_fifo: RTL and testbench
============================================

# bus_adapter_outer_in_fifo

Parametrised outer-to-hub ingress adapter: accepts words from an outer source, buffers them in a tagged FIFO, and presents them to a bus-switch input port with correct `isLast` framing. It generalises the outer-in adapter with these additions:
- configurable data width, length-field width and buffer depth;
- decoupling between outer and hub handshakes;
- an explicit transfer state machine;
- a per-transfer completion report.

It sits between an external stream and one `busSwitch` input channel.

## Interface
Parameters:
- `W`, 64, data word width in bits.
- `LEN_W`, 15, width of the size field and of the word counters.
- `DEPTH`, 4, FIFO entries; power of two, ≥ 2.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - `clk`  in  1  clock; all state on rising edge.
  - `rst`  in  1  reset, asynchronous, active-low.
- Command:
  - `cmd`  in  LEN_W  transfer size in words; 0 = automatic (hub-terminated).
  - `cmd_isReady`  in  1  command valid.
  - `cmd_canReceive`  out  1  command accepted when high together with `cmd_isReady`.
- Outer source:
  - `o__in`  in  W  outer data.
  - `o__in_isReady`  in  1  outer data valid.
  - `o__in_canReceive`  out  1  adapter accepts outer word.
- Hub side:
  - `h__in`  out  W  data to hub.
  - `h__in_isReady`  out  1  FIFO head valid.
  - `h__in_canReceive`  in  1  hub accepts word.
  - `h__in_isLast_in`  out  1  head word is last of a counted transfer.
  - `h__in_isLast_out`  in  1  hub reports last word consumed (automatic mode terminator).
- Completion report:
  - `done_count`  out  LEN_W  words delivered to hub in the finished transfer.
  - `done_isReady`  out  1  one-cycle pulse, `done_count` valid.

## Operation
- Handshakes:
  - A transfer on any channel occurs in a cycle where `_isReady` and `_canReceive` are both high.
  - Push = outer transfer; pop = hub transfer.
- FIFO entries are `{last, data}`, W+1 bits wide.
  - `h__in` = head data; `h__in_isLast_in` = head `last` & non-empty.
- States: IDLE, COUNT, AUTO, DRAIN.
  - **IDLE:** `cmd_canReceive`=1, `o__in_canReceive`=0. Command with size≠0 → COUNT, with `remaining`=size. Command with size=0 → AUTO.
  - **COUNT:** `o__in_canReceive` = ~full. Each push decrements `remaining`. The push with `remaining`=1 is tagged `last`=1 and moves to DRAIN.
  - **DRAIN:** `o__in_canReceive`=0. A pop of an entry with `last`=1 → IDLE and pulses done.
  - **AUTO:** `o__in_canReceive` = ~full; entries tagged `last`=0. A cycle with `h__in_isLast_out`=1 → IDLE and pulses done.
- Automatic-mode leftovers: words left in the FIFO after AUTO ends are not flushed. They are delivered first in the next transfer and counted there.
- `delivered` counter:
  - Cleared on command accept; +1 per pop.
  - Wraps modulo 2^LEN_W.
  - `done_count` = `delivered` including the terminating-cycle pop.
- `cmd_canReceive` is high only in IDLE. There is no command queueing.
- Reset (asynchronous, any time): state IDLE, FIFO empty, counters 0, no done pulse.
  - Outputs during and after reset: `cmd_canReceive`=1, all other outputs 0.

## Timing
- Push at edge N → word visible at `h__in` with `h__in_isReady`=1 from cycle N+1. The FIFO is fully registered with no bypass.
- Full FIFO: `o__in_canReceive`=0 even if a pop occurs in the same cycle. A push and pop in the same cycle are allowed when not full.
- Empty FIFO: `h__in_isReady`=0; `h__in` is don't-care but driven 0.
- Completion:
  - `done_isReady` pulses for exactly one cycle, the cycle after the terminating event.
  - `cmd_canReceive` rises in that same cycle.
  - Back-to-back commands are therefore spaced ≥ 1 idle cycle after termination.
- A command of size 1: COUNT → DRAIN on the first push; the word reaches the hub with `last`=1.
- Pointers are log2(DEPTH)+1 bits; full/empty are decided by MSB compare.

## Structure
- State encoding and the default `Outer_MaxWordLen`=15 go into the shared `lib.v` as defines.
- The module uses `delay`/`ff_*` library primitives where applicable.
- Sub-module: `fifo_tagged` (parameters WIDTH=W+1, DEPTH) with push/pop/full/empty, asynchronous active-low reset. It is reusable by a matching egress adapter.

## Test plan
- **Counted transfer:** cmd=3; outer pushes 0xA,0xB,0xC back-to-back; hub always ready.
  - Required: hub sees A,B,C from cycle after the first push.
  - Required: `isLast_in` only on C.
  - Required: `done_count`=3, one pulse.
- **Backpressure:** cmd=6, DEPTH=4, hub not ready for 10 cycles.
  - Required: `o__in_canReceive` drops after 4 pushes.
  - Required: after the hub is released, all 6 words are delivered in order; done=6.
- **Automatic mode:** cmd=0; push 5 words, pop 3, assert `h__in_isLast_out` with the 3rd pop.
  - Required: done=3.
  - Required: next cmd=2 delivers the 2 leftovers first, then 2 new words; done=4.
- **Size 1 and back-to-back:** cmd=1 then cmd=1 immediately.
  - Required: second command accepted only when `cmd_canReceive`=1 (cycle of the first done pulse).
- **Reset mid-transfer:** cmd=8, 3 pushes, assert rst low asynchronously between edges.
  - Required: outputs clear immediately, no done pulse, `cmd_canReceive`=1, FIFO empty.
- **Counter wrap:** LEN_W=4 in automatic mode, 17 pops before `isLast_out`.
  - Required: `done_count`=1.

Source files
------------

// File: rtl/bus_adapter_outer_in_fifo_pkg.sv
// Shared types and defaults for the outer-to-hub ingress adapter.
// Contents: transfer state encoding, default data width, length-field width and buffer depth.
package bus_adapter_outer_in_fifo_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StCount = 2'd1,
    StAuto  = 2'd2,
    StDrain = 2'd3
  } state_e;

  localparam int unsigned OuterMaxWordLen = 15;
  localparam int unsigned DefaultWidth    = 64;
  localparam int unsigned DefaultDepth    = 4;

endpackage

// File: rtl/bus_adapter_outer_in_fifo_if.sv
// Handshake bundle of the ingress adapter: command, outer source, hub port, completion report.
// Modports: master = surrounding system (drives cmd/outer data/hub acks),
//           slave  = the adapter.
interface bus_adapter_outer_in_fifo_if
  import bus_adapter_outer_in_fifo_pkg::*;
#(
  parameter int unsigned W     = DefaultWidth,
  parameter int unsigned LEN_W = OuterMaxWordLen
);
  logic [LEN_W-1:0] cmd;
  logic             cmd_isReady;
  logic             cmd_canReceive;
  logic [W-1:0]     o__in;
  logic             o__in_isReady;
  logic             o__in_canReceive;
  logic [W-1:0]     h__in;
  logic             h__in_isReady;
  logic             h__in_canReceive;
  logic             h__in_isLast_in;
  logic             h__in_isLast_out;
  logic [LEN_W-1:0] done_count;
  logic             done_isReady;

  modport master (
    output cmd, cmd_isReady, o__in, o__in_isReady, h__in_canReceive, h__in_isLast_out,
    input  cmd_canReceive, o__in_canReceive, h__in, h__in_isReady, h__in_isLast_in,
           done_count, done_isReady
  );

  modport slave (
    input  cmd, cmd_isReady, o__in, o__in_isReady, h__in_canReceive, h__in_isLast_out,
    output cmd_canReceive, o__in_canReceive, h__in, h__in_isReady, h__in_isLast_in,
           done_count, done_isReady
  );
endinterface

// File: rtl/bus_adapter_outer_in_fifo_fifo_tagged.sv
// Fully registered FIFO (no bypass) holding {tag, data} entries; reusable for ingress/egress.
// Ports: clk, rst (async active-low), push/wdata, pop/rdata, full, empty.
// rdata reads 0 when empty. Pointers carry one extra wrap bit for full/empty detection.
module bus_adapter_outer_in_fifo_fifo_tagged #(
  parameter int unsigned WIDTH = 65,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q, rptr_q;
  logic             do_push, do_pop;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = empty ? '0 : mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q[AW-1:0]] <= wdata;
        wptr_q                <= wptr_q + 1'b1;
      end
      if (do_pop) rptr_q <= rptr_q + 1'b1;
    end
  end

endmodule

// File: rtl/bus_adapter_outer_in_fifo.sv
// Outer-to-hub ingress adapter: buffers outer words in a tagged FIFO and frames them for a
// bus-switch input port, with counted or hub-terminated (automatic) transfers and a
// one-cycle completion report carrying the number of words delivered.
// Ports: clk, rst (async active-low), bus (slave side of the adapter interface).
module bus_adapter_outer_in_fifo
  import bus_adapter_outer_in_fifo_pkg::*;
#(
  parameter int unsigned W     = DefaultWidth,
  parameter int unsigned LEN_W = OuterMaxWordLen,
  parameter int unsigned DEPTH = DefaultDepth
) (
  input logic                         clk,
  input logic                         rst,
  bus_adapter_outer_in_fifo_if.slave  bus
);
  state_e           state_q;
  logic [LEN_W-1:0] remaining_q;
  logic [LEN_W-1:0] delivered_q;
  logic [LEN_W-1:0] done_count_q;
  logic             done_q;

  logic [W:0]       head;
  logic             full, empty;
  logic             push, pop, cmd_fire, push_last;
  logic [LEN_W-1:0] pop_inc;

  assign cmd_fire  = (state_q == StIdle) && bus.cmd_isReady;
  assign push      = bus.o__in_isReady && bus.o__in_canReceive;
  assign pop       = !empty && bus.h__in_canReceive;
  assign push_last = (state_q == StCount) && (remaining_q == LEN_W'(1));
  assign pop_inc   = {{(LEN_W-1){1'b0}}, pop};

  bus_adapter_outer_in_fifo_fifo_tagged #(
    .WIDTH (W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata ({push_last, bus.o__in}),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  assign bus.cmd_canReceive   = (state_q == StIdle);
  // Full blocks the outer side even when a pop frees a slot this cycle.
  assign bus.o__in_canReceive = ((state_q == StCount) || (state_q == StAuto)) && !full;
  assign bus.h__in            = head[W-1:0];
  assign bus.h__in_isReady    = !empty;
  assign bus.h__in_isLast_in  = head[W];
  assign bus.done_count       = done_count_q;
  assign bus.done_isReady     = done_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      remaining_q  <= '0;
      delivered_q  <= '0;
      done_count_q <= '0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      // A pop in the accept cycle already belongs to the new transfer.
      delivered_q <= cmd_fire ? pop_inc : delivered_q + pop_inc;
      unique case (state_q)
        StIdle: begin
          if (bus.cmd_isReady) begin
            if (bus.cmd != '0) begin
              state_q     <= StCount;
              remaining_q <= bus.cmd;
            end else begin
              state_q <= StAuto;
            end
          end
        end
        StCount: begin
          if (push) begin
            remaining_q <= remaining_q - LEN_W'(1);
            if (push_last) state_q <= StDrain;
          end
        end
        StDrain: begin
          if (pop && head[W]) begin
            state_q      <= StIdle;
            done_q       <= 1'b1;
            done_count_q <= delivered_q + pop_inc;
          end
        end
        StAuto: begin
          if (bus.h__in_isLast_out) begin
            state_q      <= StIdle;
            done_q       <= 1'b1;
            done_count_q <= delivered_q + pop_inc;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_adapter_outer_in_fifo.sv
// Bench for bus_adapter_outer_in_fifo: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, and a narrow-counter instance for wrap.
module tb_bus_adapter_outer_in_fifo;
  import bus_adapter_outer_in_fifo_pkg::*;

  localparam int unsigned W     = 64;
  localparam int unsigned LEN_W = 15;
  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  bus_adapter_outer_in_fifo_if #(.W(W), .LEN_W(LEN_W)) bus ();
  bus_adapter_outer_in_fifo_if #(.W(8), .LEN_W(4))     bus_w ();

  bus_adapter_outer_in_fifo #(.W(W), .LEN_W(LEN_W), .DEPTH(DEPTH)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  bus_adapter_outer_in_fifo #(.W(8), .LEN_W(4), .DEPTH(4)) u_wrap (
    .clk (clk),
    .rst (rst),
    .bus (bus_w)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // ---------------- reference model (main instance) ----------------
  typedef enum int {MIdle, MCount, MAuto, MDrain} mmode_e;
  mmode_e      m_mode = MIdle;
  mmode_e      m_old  = MIdle;
  int          m_rem = 0, m_deliv = 0, m_done_val = 0;
  bit          m_done = 0, m_push = 0, m_pop = 0, m_head_last = 0;
  logic [64:0] m_q[$];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_q.delete();
      m_mode = MIdle; m_rem = 0; m_deliv = 0; m_done = 0; m_done_val = 0;
    end else begin
      m_old       = m_mode;
      m_push      = (m_old == MCount || m_old == MAuto) && (m_q.size() < DEPTH)
                    && bus.o__in_isReady;
      m_pop       = (m_q.size() > 0) && bus.h__in_canReceive;
      m_head_last = m_pop && m_q[0][64];
      m_done      = 0;
      if (m_pop) begin
        void'(m_q.pop_front());
        m_deliv++;
      end
      if (m_old == MIdle && bus.cmd_isReady) begin
        m_deliv = m_pop ? 1 : 0;
        if (bus.cmd != 0) begin
          m_mode = MCount;
          m_rem  = int'(bus.cmd);
        end else begin
          m_mode = MAuto;
        end
      end
      if ((m_old == MDrain && m_head_last) || (m_old == MAuto && bus.h__in_isLast_out)) begin
        m_mode     = MIdle;
        m_done     = 1;
        m_done_val = m_deliv;
      end
      if (m_push) begin
        m_q.push_back({(m_old == MCount) && (m_rem == 1), bus.o__in});
        if (m_old == MCount) begin
          m_rem--;
          if (m_rem == 0) m_mode = MDrain;
        end
      end
    end
  end

  // ---------------- per-cycle compare and logs ----------------
  logic [64:0] recv_log[$];
  int          done_log[$];

  always @(negedge clk) begin
    check("cmd_canReceive", bus.cmd_canReceive, m_mode == MIdle);
    check("o_canReceive", bus.o__in_canReceive,
          (m_mode == MCount || m_mode == MAuto) && (m_q.size() < DEPTH));
    check("h_isReady", bus.h__in_isReady, m_q.size() > 0);
    check("h_data", bus.h__in, (m_q.size() > 0) ? m_q[0][63:0] : 64'h0);
    check("h_isLast_in", bus.h__in_isLast_in, (m_q.size() > 0) ? m_q[0][64] : 1'b0);
    check("done_isReady", bus.done_isReady, m_done);
    if (m_done) check("done_count", bus.done_count, 64'(m_done_val & 32'h7FFF));
    if (bus.h__in_isReady && bus.h__in_canReceive)
      recv_log.push_back({bus.h__in_isLast_in, bus.h__in});
    if (bus.done_isReady) done_log.push_back(int'(bus.done_count));
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input int size, output bit with_done);
    bit fire = 0;
    with_done   = 0;
    bus.cmd         = LEN_W'(size);
    bus.cmd_isReady = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      fire      = bus.cmd_canReceive;
      with_done = bus.done_isReady;
      step();
      if (fire) break;
    end
    bus.cmd_isReady = 1'b0;
    bus.cmd         = '0;
    if (!fire) timeout("cmd_accept");
  endtask

  task automatic push_seq(input logic [63:0] base, input int n);
    bit fire;
    for (int k = 0; k < n; k++) begin
      fire              = 0;
      bus.o__in         = base + 64'(k);
      bus.o__in_isReady = 1'b1;
      for (int i = 0; i < 200; i++) begin
        @(negedge clk);
        fire = bus.o__in_canReceive;
        step();
        if (fire) break;
      end
      if (!fire) begin
        timeout("outer_push");
        break;
      end
    end
    bus.o__in_isReady = 1'b0;
    bus.o__in         = '0;
  endtask

  task automatic wait_done(input int prev);
    bit seen = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (done_log.size() > prev) begin
        seen = 1;
        break;
      end
    end
    if (!seen) timeout("done_pulse");
  endtask

  task automatic check_recv(input string name, input logic [63:0] base, input int n,
                            input int first_new, input logic [63:0] new_base);
    check({name, "_n"}, 64'(recv_log.size()), 64'(n));
    for (int i = 0; i < n && i < recv_log.size(); i++) begin
      check({name, "_data"}, recv_log[i][63:0],
            (i < first_new) ? base + 64'(i) : new_base + 64'(i - first_new));
      check({name, "_last"}, 64'(recv_log[i][64]), 64'(i == n - 1));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int prev;
  bit acc;
  int wpops;

  initial begin
    bus.cmd = '0; bus.cmd_isReady = 0; bus.o__in = '0; bus.o__in_isReady = 0;
    bus.h__in_canReceive = 0; bus.h__in_isLast_out = 0;
    bus_w.cmd = '0; bus_w.cmd_isReady = 0; bus_w.o__in = '0; bus_w.o__in_isReady = 0;
    bus_w.h__in_canReceive = 0; bus_w.h__in_isLast_out = 0;

    // Reset state
    #3;
    check("rst_cmd_canReceive", bus.cmd_canReceive, 1);
    check("rst_o_canReceive", bus.o__in_canReceive, 0);
    check("rst_h_isReady", bus.h__in_isReady, 0);
    check("rst_done_isReady", bus.done_isReady, 0);
    check("rst_done_count", bus.done_count, 0);
    step();
    rst = 1'b1;
    repeat (2) step();

    // Counted transfer of 3, hub always ready
    bus.h__in_canReceive = 1;
    recv_log.delete();
    prev = done_log.size();
    send_cmd(3, acc);
    push_seq(64'hA, 3);
    wait_done(prev);
    repeat (3) step();
    check_recv("t1", 64'hA, 3, 3, 64'h0);
    check("t1_pulses", 64'(done_log.size()), 64'(prev + 1));
    check("t1_done", 64'(done_log[prev]), 3);

    // Backpressure: 6 words into a 4-deep FIFO with the hub stalled
    bus.h__in_canReceive = 0;
    recv_log.delete();
    prev = done_log.size();
    send_cmd(6, acc);
    fork
      push_seq(64'h100, 6);
    join_none
    repeat (10) step();
    @(negedge clk);
    check("t2_o_blocked", bus.o__in_canReceive, 0);
    check("t2_head", bus.h__in, 64'h100);
    step();
    bus.h__in_canReceive = 1;
    wait fork;
    wait_done(prev);
    check_recv("t2", 64'h100, 6, 6, 64'h0);
    check("t2_done", 64'(done_log[prev]), 6);

    // Automatic mode: 5 pushed, 3 popped, terminator with the third pop
    bus.h__in_canReceive = 0;
    prev = done_log.size();
    send_cmd(0, acc);
    fork
      push_seq(64'h200, 5);
    join_none
    repeat (6) step();
    bus.h__in_canReceive = 1;
    step();
    step();
    bus.h__in_isLast_out = 1;
    step();
    bus.h__in_isLast_out = 0;
    bus.h__in_canReceive = 0;
    wait fork;
    wait_done(prev);
    check("t3_done", 64'(done_log[prev]), 3);
    // Leftovers 0x203/0x204 come first in the next counted transfer
    recv_log.delete();
    prev = done_log.size();
    send_cmd(2, acc);
    push_seq(64'h300, 2);
    bus.h__in_canReceive = 1;
    wait_done(prev);
    check_recv("t3b", 64'h203, 4, 2, 64'h300);
    check("t3b_done", 64'(done_log[prev]), 4);

    // Size 1, back-to-back
    prev = done_log.size();
    send_cmd(1, acc);
    push_seq(64'h400, 1);
    send_cmd(1, acc);
    check("t4_accept_on_done", 64'(acc), 1);
    push_seq(64'h401, 1);
    wait_done(prev + 1);
    check("t4_pulses", 64'(done_log.size()), 64'(prev + 2));
    check("t4_done_a", 64'(done_log[prev]), 1);
    check("t4_done_b", 64'(done_log[prev + 1]), 1);

    // Asynchronous reset in the middle of a counted transfer
    bus.h__in_canReceive = 0;
    send_cmd(8, acc);
    push_seq(64'h500, 3);
    #2;
    rst = 1'b0;
    #1;
    check("t5_cmd_canReceive", bus.cmd_canReceive, 1);
    check("t5_o_canReceive", bus.o__in_canReceive, 0);
    check("t5_h_isReady", bus.h__in_isReady, 0);
    check("t5_h_data", bus.h__in, 0);
    check("t5_isLast_in", bus.h__in_isLast_in, 0);
    check("t5_done_isReady", bus.done_isReady, 0);
    prev = done_log.size();
    step();
    step();
    rst = 1'b1;
    repeat (3) step();
    check("t5_no_done", 64'(done_log.size()), 64'(prev));
    check("t5_fifo_empty", bus.h__in_isReady, 0);

    // Counter wrap on a 4-bit instance: 17 pops in automatic mode
    bus_w.cmd              = '0;
    bus_w.cmd_isReady      = 1;
    bus_w.h__in_canReceive = 1;
    bus_w.o__in_isReady    = 1;
    bus_w.o__in            = 8'h5A;
    step();
    bus_w.cmd_isReady = 0;
    wpops = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus_w.h__in_isReady) begin
        if (wpops == 16) bus_w.h__in_isLast_out = 1;
        wpops++;
      end
      step();
      if (bus_w.h__in_isLast_out) break;
    end
    if (!bus_w.h__in_isLast_out) timeout("wrap_pops");
    bus_w.h__in_isLast_out = 0;
    bus_w.o__in_isReady    = 0;
    bus_w.h__in_canReceive = 0;
    @(negedge clk);
    check("t6_done_isReady", bus_w.done_isReady, 1);
    check("t6_done_count", bus_w.done_count, 1);
    check("t6_cmd_canReceive", bus_w.cmd_canReceive, 1);
    step();
    @(negedge clk);
    check("t6_single_pulse", bus_w.done_isReady, 0);

    repeat (3) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
